// File: rtl/uart_stream_emitter.sv
// AXI-Stream to UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser,
// with end-of-frame pulse for tlast bytes and a status LED.
module uart_stream_emitter #(
    parameter int unsigned CLK_FREQ_HZ = 16_000_000,
    parameter int unsigned BAUD        = 57_600,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned LED_MODE    = 0,
    parameter int unsigned LED_HOLD    = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_tdata,
    input  logic       i_tlast,
    input  logic       i_tvalid,
    output logic       o_tready,
    output logic       o_uart_tx,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_led
);

    localparam int unsigned DIV = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
    localparam int unsigned AW  = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned LW  = $clog2(LED_HOLD + 2);
    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [LW-1:0] LED_LOAD = LW'(LED_HOLD);

    if (DIV < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || (STOP_BITS != 1 && STOP_BITS != 2)
        || PARITY > 2 || LED_MODE > 1) begin : gen_param_check
        $error("uart_stream_emitter: illegal parameter combination");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count, count_next;
    logic [8:0]    head;
    logic          push, pop;

    state_e        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic          stop_idx;
    logic [7:0]    shreg;
    logic          last_q, par_q, tx_q, frame_done_q, busy_q;
    logic          bit_end, frame_end, fsm_active_next;
    logic [LW-1:0] led_cnt;

    assign o_tready = !i_rst && (count != FULL_CNT);
    assign push     = i_tvalid && o_tready;
    assign head     = mem[rptr];

    assign bit_end   = (baud_cnt == '0);
    assign frame_end = (state == StStop) && bit_end && (stop_idx == 1'(STOP_BITS - 1));
    // The idle and final-stop pops both chain straight into a start bit
    assign pop       = (count != '0) && ((state == StIdle) || frame_end);
    assign fsm_active_next = pop || ((state != StIdle) && !frame_end);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wptr] <= {i_tlast, i_tdata};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= StIdle;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            last_q       <= 1'b0;
            par_q        <= 1'b0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= frame_end && last_q;
            busy_q       <= (count_next != '0) || fsm_active_next;
            if (pop) begin
                state    <= StStart;
                baud_cnt <= DIV_M1;
                shreg    <= head[7:0];
                last_q   <= head[8];
                par_q    <= (PARITY == 1) ? ~^head[7:0] : ^head[7:0];
                tx_q     <= 1'b0;
            end else if (state != StIdle) begin
                if (!bit_end) begin
                    baud_cnt <= baud_cnt - 1'b1;
                end else begin
                    baud_cnt <= DIV_M1;
                    unique case (state)
                        StStart: begin
                            state   <= StData;
                            bit_idx <= '0;
                            tx_q    <= shreg[0];
                        end
                        StData: begin
                            if (bit_idx == 3'd7) begin
                                if (PARITY != 0) begin
                                    state <= StParity;
                                    tx_q  <= par_q;
                                end else begin
                                    state    <= StStop;
                                    stop_idx <= 1'b0;
                                    tx_q     <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                                shreg   <= shreg >> 1;
                                tx_q    <= shreg[1];
                            end
                        end
                        StParity: begin
                            state    <= StStop;
                            stop_idx <= 1'b0;
                            tx_q     <= 1'b1;
                        end
                        StStop: begin
                            tx_q <= 1'b1;
                            if (frame_end) begin
                                state <= StIdle;
                            end else begin
                                stop_idx <= 1'b1;
                            end
                        end
                        default: state <= StIdle;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            led_cnt <= '0;
        end else if (state != StIdle) begin
            led_cnt <= LED_LOAD;
        end else if (led_cnt != '0) begin
            led_cnt <= led_cnt - 1'b1;
        end
    end

    assign o_uart_tx    = tx_q;
    assign o_busy       = busy_q;
    assign o_frame_done = frame_done_q;
    assign o_led        = (LED_MODE == 1) ? (led_cnt != '0) : tx_q;

endmodule
